// File: rtl/uart_resend_sched_if.sv
// Handshake bundle between the per-channel receive FSMs and the shared
// resend scheduler: requests and link ack in, grant/strobe/status out.
interface uart_resend_sched_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] req;
  logic            ack;
  logic [N_CH-1:0] grant;
  logic            resend_start;
  logic            busy;
  logic [N_CH-1:0] done;
  logic [N_CH-1:0] fail;
  logic [2:0]      retry_cnt;
  logic [4:0]      timer;

  modport master (
    output req, ack,
    input  grant, resend_start, busy, done, fail, retry_cnt, timer
  );

  modport slave (
    input  req, ack,
    output grant, resend_start, busy, done, fail, retry_cnt, timer
  );
endinterface

// File: rtl/uart_resend_sched.sv
// Round-robin resend scheduler: grants one channel at a time to the shared
// UART retransmitter, times out unacked attempts and retries up to MAX_RETRY.
module uart_resend_sched #(
  parameter int N_CH      = 4,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                reset,
  uart_resend_sched_if.slave  bus
);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [N_CH-1:0] grant_q;
  logic            start_q;
  logic            busy_q;
  logic [N_CH-1:0] done_q;
  logic [N_CH-1:0] fail_q;
  logic [2:0]      retry_q;
  logic [4:0]      timer_q;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand_idx;
  int              cand;

  // Search starts just after the last winner so a served channel drops to the back
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand     = (int'(last) + i) % N_CH;
      cand_idx = IW'(cand);
      if (!pick_valid && bus.req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last    <= IW'(N_CH - 1);
      grant_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      fail_q  <= '0;
      retry_q <= '0;
      timer_q <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      fail_q  <= '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= N_CH'(1) << pick_idx;
            last    <= pick_idx;
            retry_q <= '0;
            timer_q <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          // An ack on the final timeout cycle still counts as success
          if (bus.ack) begin
            done_q  <= grant_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else if (timer_q == 5'(TIMEOUT - 1)) begin
            if (retry_q < 3'(MAX_RETRY)) begin
              retry_q <= retry_q + 3'd1;
              timer_q <= '0;
              start_q <= 1'b1;
              state   <= SEND;
            end else begin
              fail_q  <= grant_q;
              grant_q <= '0;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            timer_q <= timer_q + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.resend_start = start_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.retry_cnt    = retry_q;
  assign bus.timer        = timer_q;
endmodule

// File: tb/tb_uart_resend_sched.sv
// Directed bench for uart_resend_sched: a cycle table for basic service and
// round-robin order, plus sequences for timeout/retry, late ack and reset.
module tb_uart_resend_sched;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  uart_resend_sched_if #(.N_CH(4)) bus ();

  uart_resend_sched #(.N_CH(4), .TIMEOUT(8), .MAX_RETRY(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_first;
    logic [3:0] req;
    logic       ack;
    logic [3:0] grant;
    logic       rs;
    logic       busy;
    logic [3:0] done;
    logic [3:0] fail;
    logic [2:0] rc;
    logic [4:0] tmr;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [31:0] pack_vals(logic [3:0] g, logic rs, logic b,
                                            logic [3:0] d, logic [3:0] f,
                                            logic [2:0] rc, logic [4:0] t);
    return {11'd0, g, rs, b, d, f, rc, t};
  endfunction

  function automatic logic [31:0] pack_out();
    return pack_vals(bus.grant, bus.resend_start, bus.busy, bus.done,
                     bus.fail, bus.retry_cnt, bus.timer);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are set away from the edge; outputs are readable 1 ns after it
  task automatic apply_stimulus(input logic [3:0] r, input logic a);
    bus.req = r;
    bus.ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    bus.ack = 1'b0;
    #12;
    reset   = 1'b0;
  endtask

  initial begin
    int cyc;
    int n_strobe;
    int strobe_cyc[8];
    int strobe_rc[8];
    int fail_cyc;
    int fail_cnt;
    logic [3:0] fail_val;
    logic [3:0] fail_grant;
    logic [2:0] fail_rc;
    logic found;
    int done_seen;

    tests_run    = 0;
    tests_failed = 0;
    bus.req      = '0;
    bus.ack      = 1'b0;
    reset        = 1'b0;

    //           rst   req      ack   grant    rs    busy  done     fail     rc  tmr
    vecs[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, 0, 1};
    vecs[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, 0, 2};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 0, 2};
    vecs[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 0, 2};
    vecs[6]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 0, 0};
    vecs[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[10] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[11] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 0, 0};
    vecs[12] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[13] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[14] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 0, 0};
    vecs[15] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[16] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[17] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000, 0, 0};
    vecs[18] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[19] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, 0, 0};
    vecs[20] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 0, 0};
    vecs[21] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 0, 0};

    do_reset();
    check_output("reset_state", pack_out(), 32'd0);

    for (int i = 0; i < 22; i++) begin
      if (vecs[i].rst_first) do_reset();
      apply_stimulus(vecs[i].req, vecs[i].ack);
      check_output($sformatf("vec%0d", i), pack_out(),
                   pack_vals(vecs[i].grant, vecs[i].rs, vecs[i].busy, vecs[i].done,
                             vecs[i].fail, vecs[i].rc, vecs[i].tmr));
    end

    // Never acked: four attempts nine cycles apart, then a single fail pulse
    do_reset();
    apply_stimulus(4'b0001, 1'b0);
    n_strobe   = 0;
    fail_cyc   = -1;
    fail_cnt   = 0;
    fail_val   = '0;
    fail_grant = 4'hF;
    fail_rc    = '0;
    for (cyc = 0; cyc < 45; cyc++) begin
      if (cyc > 0) apply_stimulus(4'b0000, 1'b0);
      if (bus.resend_start && n_strobe < 8) begin
        strobe_cyc[n_strobe] = cyc;
        strobe_rc[n_strobe]  = int'(bus.retry_cnt);
        n_strobe++;
      end
      if (bus.fail != 4'b0000) begin
        fail_cnt++;
        if (fail_cyc < 0) begin
          fail_cyc   = cyc;
          fail_val   = bus.fail;
          fail_grant = bus.grant;
          fail_rc    = bus.retry_cnt;
        end
      end
    end
    check_output("timeout_strobe_count", 32'(n_strobe), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_strobe) begin
        check_output($sformatf("timeout_rc_at_strobe%0d", k), 32'(strobe_rc[k]), 32'(k));
        if (k > 0)
          check_output($sformatf("timeout_spacing%0d", k),
                       32'(strobe_cyc[k] - strobe_cyc[k-1]), 32'd9);
      end
    end
    check_output("timeout_fail_cycle", 32'(fail_cyc), 32'd36);
    check_output("timeout_fail_value", 32'(fail_val), 32'b0001);
    check_output("timeout_fail_count", 32'(fail_cnt), 32'd1);
    check_output("timeout_grant_after", 32'(fail_grant), 32'd0);
    check_output("timeout_rc_final", 32'(fail_rc), 32'd3);

    // Ack on the very last wait cycle of the last attempt must win over fail
    do_reset();
    apply_stimulus(4'b0001, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (bus.retry_cnt == 3'd3 && bus.timer == 5'd7 && bus.busy) found = 1'b1;
      else apply_stimulus(4'b0000, 1'b0);
    end
    check_output("lastack_reached", 32'(found), 32'd1);
    apply_stimulus(4'b0000, 1'b1);
    check_output("lastack_done", 32'(bus.done), 32'b0001);
    check_output("lastack_no_fail", {bus.fail, bus.grant, 3'd0, bus.busy}, 32'd0);
    apply_stimulus(4'b0000, 1'b0);
    check_output("lastack_quiet_after", {bus.fail, bus.done}, 32'd0);

    // Ack held only during SEND is ignored; the attempt times out and retries
    do_reset();
    apply_stimulus(4'b0001, 1'b0);
    check_output("sendack_strobe", 32'(bus.resend_start), 32'd1);
    apply_stimulus(4'b0000, 1'b1);
    cyc       = 1;
    done_seen = 0;
    found     = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      apply_stimulus(4'b0000, 1'b0);
      cyc++;
      if (bus.done != 4'b0000) done_seen++;
      if (bus.resend_start) found = 1'b1;
    end
    check_output("sendack_retry_seen", 32'(found), 32'd1);
    check_output("sendack_retry_cycle", 32'(cyc), 32'd9);
    check_output("sendack_retry_cnt", 32'(bus.retry_cnt), 32'd1);
    check_output("sendack_no_done", 32'(done_seen), 32'd0);

    // Async reset in the middle of WAIT clears everything without waiting for a clock
    do_reset();
    apply_stimulus(4'b0010, 1'b0);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0000, 1'b0);
    check_output("midreset_pre_busy", 32'(bus.busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_output("midreset_immediate", pack_out(), 32'd0);
    #2;
    reset = 1'b0;
    apply_stimulus(4'b1111, 1'b0);
    check_output("midreset_pointer", 32'(bus.grant), 32'b0001);
    check_output("midreset_no_pulse", {bus.done, bus.fail}, 32'd0);
    do_reset();
    apply_stimulus(4'b1000, 1'b0);
    check_output("midreset_ch3_grant", {bus.grant, 3'd0, bus.resend_start}, {4'b1000, 3'd0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
